// File: rtl/mult_seq.sv
// Operand sequencer feeding a repeated-addition multiplier: queues (A,B) pairs,
// issues them one at a time and returns products in order. Optional watchdog: MULT_SEQ_WDOG_EN.
module mult_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    output logic                    mul_start,
    output logic [DATA_WIDTH-1:0]   mul_a,
    output logic [DATA_WIDTH-1:0]   mul_b,
    input  logic                    mul_rdy,
    input  logic [2*DATA_WIDTH-1:0] mul_p,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_p,
    output logic                    busy,
    output logic                    err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem_a [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   r_mem_b [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_first;
    logic                    r_res_valid;
    logic [2*DATA_WIDTH-1:0] r_res_p;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_nonempty;
    logic                    w_capture;

    assign in_ready   = (r_count != FULL_CNT);
    assign w_nonempty = (r_count != '0);
    assign w_push     = in_valid & in_ready;
    assign w_pop      = mul_start;
    assign mul_a      = r_mem_a[r_rd_ptr];
    assign mul_b      = r_mem_b[r_rd_ptr];
    assign res_valid  = r_res_valid;
    assign res_p      = r_res_p;
    assign busy       = w_nonempty | (r_state == ST_WAIT) | r_res_valid;

`ifdef MULT_SEQ_WDOG_EN
    localparam int WDW = DATA_WIDTH + 1;
    // Counter value in the last allowed WAIT cycle (2^W+4 WAIT cycles total).
    localparam logic [WDW-1:0] WDOG_LAST = WDW'((1 << DATA_WIDTH) + 3);
    logic [WDW-1:0] r_wdog;
    logic           r_err;
    logic           w_timeout;
`endif

    always_comb begin
        w_state_nxt = r_state;
        mul_start   = 1'b0;
        w_capture   = 1'b0;
`ifdef MULT_SEQ_WDOG_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_nonempty && mul_rdy && (!r_res_valid || res_ready)) begin
                    mul_start   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The multiplier's rdy only drops one cycle after start.
                if (!r_first && mul_rdy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`ifdef MULT_SEQ_WDOG_EN
                else if (r_wdog == WDOG_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= mul_start;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_res_valid <= 1'b0;
            r_res_p     <= '0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_p     <= mul_p;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef MULT_SEQ_WDOG_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wdog <= (r_state == ST_WAIT) ? r_wdog + WDW'(1) : '0;
            r_err  <= r_err | w_timeout;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq with a behavioural repeated-addition multiplier
// and a product scoreboard; define MULT_SEQ_WDOG_EN to also exercise the watchdog.
module tb_mult_seq;
    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_rdy;
    logic [PW-1:0] mul_p;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [PW-1:0] res_p;
    logic          busy;
    logic          err;

    int n_total = 0;
    int n_bad   = 0;
    int n_res   = 0;
    logic saw_full = 1'b0;
    logic [PW-1:0] exp_q[$];

    always #5 clk = ~clk;

    mult_seq #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_rdy(mul_rdy), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
        .busy(busy), .err(err)
    );

    // Multiplier: rdy low for a+1 cycles after start, product built by repeated addition.
    logic          m_busy;
    logic          m_stall = 1'b0;
    logic [W-1:0]  m_cnt;
    logic [W-1:0]  m_b;
    logic [PW-1:0] m_acc;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mul_rdy <= 1'b1;
            mul_p   <= '0;
            m_busy  <= 1'b0;
            m_cnt   <= '0;
            m_b     <= '0;
            m_acc   <= '0;
        end else if (!m_busy) begin
            if (mul_start && mul_rdy) begin
                m_busy  <= 1'b1;
                mul_rdy <= 1'b0;
                m_cnt   <= mul_a;
                m_b     <= mul_b;
                m_acc   <= '0;
            end
        end else if (m_cnt == '0) begin
            if (!m_stall) begin
                mul_rdy <= 1'b1;
                mul_p   <= m_acc;
                m_busy  <= 1'b0;
            end
        end else begin
            m_cnt <= m_cnt - W'(1);
            m_acc <= m_acc + {{W{1'b0}}, m_b};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every accepted pair owes one product, returned in acceptance order.
    always @(negedge clk) begin
        if (rst_b) begin
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (in_valid && in_ready) exp_q.push_back(PW'(in_a) * PW'(in_b));
            if (res_valid && res_ready) begin
                n_res++;
                if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
                else check("sb_res", 32'(res_p), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (!busy && exp_q.size() == 0) break;
            tick();
        end
        check(tag, 32'(busy), 0);
    endtask

    task automatic push(input int a, input int b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = W'(a);
        in_b = W'(b);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        check("push_accept", 32'(ok), 1);
    endtask

    task automatic run_single(input int a, input int b);
        int found;
        wait_idle("pre_idle");
        in_valid = 1'b1;
        in_a = W'(a);
        in_b = W'(b);
        @(negedge clk);
        check("acc_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("start_c1", 32'(mul_start), 1);
        check("mul_a", 32'(mul_a), a);
        check("mul_b", 32'(mul_b), b);
        found = 0;
        for (int k = 2; k < 700; k++) begin
            tick();
            @(negedge clk);
            if (res_valid) begin
                found = k;
                break;
            end
        end
        check("latency", found, a + 4);
        check("res_p", 32'(res_p), a * b);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] held;
        int found;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_mul_start", 32'(mul_start), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_p", 32'(res_p), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        tick();
        rst_b = 1'b1;
        tick();

        // Single, zero operands, maximum operands
        run_single(3, 5);
        run_single(0, 9);
        run_single(9, 0);
        run_single(255, 255);

        // Burst with in_valid held: queue fills, results return in order
        wait_idle("burst_pre");
        saw_full = 1'b0;
        n_res = 0;
        for (int i = 1; i <= 6; i++) push(1, i);
        wait_idle("burst_drain");
        check("burst_full_seen", 32'(saw_full), 1);
        check("burst_count", n_res, 6);

        // Backpressure: result held, no launch until accepted
        wait_idle("bp_pre");
        res_ready = 1'b0;
        push(2, 3);
        push(4, 5);
        push(1, 7);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        check("bp_valid", found, 1);
        check("bp_first", 32'(res_p), 6);
        held = res_p;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            check("bp_hold", 32'(res_p), 32'(held));
            check("bp_nostart", 32'(mul_start), 0);
        end
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_launch", 32'(mul_start), 1);
        tick();
        wait_idle("bp_drain");

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 15));
            in_b = W'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle("rand_drain");
        check("rand_queue_empty", exp_q.size(), 0);

        // Reset mid-WAIT with three ops queued
        push(60, 1);
        push(60, 2);
        push(60, 3);
        push(60, 4);
        repeat (5) tick();
        @(negedge clk);
        check("rst_pre_busy", 32'(busy), 1);
        tick();
        rst_b = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("mrst_in_ready", 32'(in_ready), 1);
        check("mrst_mul_start", 32'(mul_start), 0);
        check("mrst_res_valid", 32'(res_valid), 0);
        check("mrst_res_p", 32'(res_p), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_err", 32'(err), 0);
        tick();
        rst_b = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_res_valid", 32'(res_valid), 0);
        tick();
        run_single(7, 11);

`ifdef MULT_SEQ_WDOG_EN
        // Watchdog: multiplier never returns rdy
        wait_idle("wd_pre");
        m_stall = 1'b1;
        in_valid = 1'b1;
        in_a = W'(2);
        in_b = W'(3);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("wd_start", 32'(mul_start), 1);
        found = 0;
        for (int k = 1; k < 400; k++) begin
            tick();
            @(negedge clk);
            if (err) begin
                found = k;
                break;
            end
        end
        check("wd_err_cycle", found, 261);
        check("wd_no_result", 32'(res_valid), 0);
        check("wd_idle", 32'(busy), 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        m_stall = 1'b0;
        repeat (5) tick();
        run_single(5, 6);
        check("wd_sticky", 32'(err), 1);
`endif

        wait_idle("final_idle");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
